// File: rtl/bpu_pkg.sv
// Shared types for the branch predictor: 2-bit saturating counter, its
// update helper, and the IF->ID prediction record.
package bpu_pkg;

    typedef logic [1:0] cnt_t;

    localparam cnt_t CNT_SNT = 2'd0;
    localparam cnt_t CNT_WNT = 2'd1;
    localparam cnt_t CNT_WT  = 2'd2;
    localparam cnt_t CNT_ST  = 2'd3;

    // Record fields are sized for the widest supported configuration;
    // instances zero-extend into them.
    localparam int unsigned REC_XLEN   = 64;
    localparam int unsigned REC_PIDX_W = 16;

    typedef struct packed {
        logic                  hit;
        logic                  pred;
        logic [REC_XLEN-1:0]   target;
        logic [REC_PIDX_W-1:0] pidx;
    } id_rec_t;

    // Saturating 2-bit counter step
    function automatic cnt_t sat_update(input cnt_t cnt, input logic taken);
        cnt_t res;
        res = cnt;
        if (taken) begin
            if (cnt != CNT_ST) res = cnt + 2'd1;
        end else begin
            if (cnt != CNT_SNT) res = cnt - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bpu_gshare_if.sv
// Fetch/decode side bus of the branch predictor.
//   pc_if, pc_id      : PCs in IF and ID
//   data_stall        : pipeline hold
//   is_branch_id, taken_id, target_id : resolved branch info in ID
//   fail, npc         : misprediction flag and next fetch PC (combinational)
interface bpu_gshare_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] pc_if;
    logic [XLEN-1:0] pc_id;
    logic            data_stall;
    logic            is_branch_id;
    logic            taken_id;
    logic [XLEN-1:0] target_id;
    logic            fail;
    logic [XLEN-1:0] npc;

    modport master (
        output pc_if, pc_id, data_stall, is_branch_id, taken_id, target_id,
        input  fail, npc
    );

    modport slave (
        input  pc_if, pc_id, data_stall, is_branch_id, taken_id, target_id,
        output fail, npc
    );
endinterface

// File: rtl/bpu_btb.sv
// Direct-mapped tagged branch target buffer.
//   clk, rst        : clock, async active-low clear of valid bits
//   rd_word         : lookup word address (pc[XLEN-1:2])
//   rd_hit_c        : lookup hit (combinational)
//   rd_target_c     : stored target at lookup index (combinational)
//   wr_en/wr_word/wr_target : install or overwrite an entry
module bpu_btb #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-3:0] rd_word,
    output logic            rd_hit_c,
    output logic [XLEN-1:0] rd_target_c,
    input  logic            wr_en,
    input  logic [XLEN-3:0] wr_word,
    input  logic [XLEN-1:0] wr_target
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = XLEN - 2 - IDX_W;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag_mem [ENTRIES];
    logic [XLEN-1:0]    tgt_mem [ENTRIES];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [TAG_W-1:0] wr_tag;

    assign rd_idx = rd_word[IDX_W-1:0];
    assign rd_tag = rd_word[XLEN-3:IDX_W];
    assign wr_idx = wr_word[IDX_W-1:0];
    assign wr_tag = wr_word[XLEN-3:IDX_W];

    // Lookup sees pre-write contents; no write bypass
    always_comb begin
        rd_hit_c    = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
        rd_target_c = tgt_mem[rd_idx];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Payload arrays are qualified by valid, so they need no reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx] <= wr_tag;
            tgt_mem[wr_idx] <= wr_target;
        end
    end
endmodule

// File: rtl/bpu_gshare.sv
// Branch predictor between IF and ID: BTB + 2-bit counter PHT, resolved in ID.
//   clk, rst : clock, async active-low reset
//   bus      : bpu_gshare_if.slave (pc_if, pc_id, data_stall, is_branch_id,
//              taken_id, target_id in; fail, npc out, both combinational)
// Build option: define BPU_GSHARE_EN to XOR global history into the PHT
// index; otherwise the predictor is bimodal and has no history register.
module bpu_gshare
    import bpu_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BTB_ENTRIES = 16,
    parameter int unsigned PHT_ENTRIES = 64,
    parameter int unsigned GHR_BITS    = 6
) (
    input logic         clk,
    input logic         rst,
    bpu_gshare_if.slave bus
);
    localparam int unsigned PIDX_W = $clog2(PHT_ENTRIES);

    if (GHR_BITS < 1 || GHR_BITS > PIDX_W) begin : g_bad_ghr
        $error("GHR_BITS must be in 1..log2(PHT_ENTRIES)");
    end
    if (XLEN > REC_XLEN || PIDX_W > REC_PIDX_W) begin : g_bad_rec
        $error("XLEN or PHT index exceeds ID record field width");
    end

    cnt_t            pht [PHT_ENTRIES];
    id_rec_t         id_q;
    id_rec_t         rec_if;
    logic [PIDX_W-1:0] pidx_if;
    logic            btb_hit_c;
    logic [XLEN-1:0] btb_target_c;
    logic            pred_if;
    logic            dir_fail;
    logic            tgt_fail;
    logic            fail_c;
    logic            upd;

    assign upd = !bus.data_stall && bus.is_branch_id;

`ifdef BPU_GSHARE_EN
    logic [GHR_BITS-1:0] ghr;

    assign pidx_if = bus.pc_if[2 +: PIDX_W] ^ PIDX_W'(ghr);

    // Non-speculative history: shifted only by resolved branches
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr <= '0;
        end else if (upd) begin
            ghr <= GHR_BITS'({ghr, bus.taken_id});
        end
    end
`else
    assign pidx_if = bus.pc_if[2 +: PIDX_W];
`endif

    bpu_btb #(
        .XLEN    (XLEN),
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .rd_word     (bus.pc_if[XLEN-1:2]),
        .rd_hit_c    (btb_hit_c),
        .rd_target_c (btb_target_c),
        .wr_en       (upd && bus.taken_id),
        .wr_word     (bus.pc_id[XLEN-1:2]),
        .wr_target   (bus.target_id)
    );

    // IF-stage prediction and the record it leaves for ID
    always_comb begin
        pred_if       = btb_hit_c && (pht[pidx_if] >= CNT_WT);
        rec_if        = '0;
        rec_if.hit    = btb_hit_c;
        rec_if.pred   = pred_if;
        rec_if.target = REC_XLEN'(btb_target_c);
        rec_if.pidx   = REC_PIDX_W'(pidx_if);
    end

    // ID-stage resolution and next fetch PC
    always_comb begin
        dir_fail = bus.is_branch_id ? (id_q.pred ^ bus.taken_id) : id_q.pred;
        tgt_fail = bus.is_branch_id && bus.taken_id && id_q.hit && id_q.pred
                   && (id_q.target != REC_XLEN'(bus.target_id));
        fail_c   = dir_fail || tgt_fail;
        bus.fail = fail_c;
        if (fail_c) begin
            bus.npc = (bus.is_branch_id && bus.taken_id) ? bus.target_id
                                                         : bus.pc_id + XLEN'(4);
        end else if (pred_if) begin
            bus.npc = btb_target_c;
        end else begin
            bus.npc = bus.pc_if + XLEN'(4);
        end
    end

    // A failing ID squashes the wrong-path IF record so it cannot fail again
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_q <= '0;
        end else if (!bus.data_stall) begin
            id_q <= fail_c ? '0 : rec_if;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < PHT_ENTRIES; i++) begin
                pht[i] <= CNT_WNT;
            end
        end else if (upd) begin
            for (int unsigned i = 0; i < PHT_ENTRIES; i++) begin
                if (id_q.pidx == REC_PIDX_W'(i)) begin
                    pht[i] <= sat_update(pht[i], bus.taken_id);
                end
            end
        end
    end
endmodule

// File: tb/tb_bpu_gshare.sv
// Self-checking bench for bpu_gshare: directed vector table, hand-written
// stall/reset/alias sequences and a random phase against a reference model.
// Follows the BPU_GSHARE_EN build option of the design.
module tb_bpu_gshare;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned BTB_N  = 16;
    localparam int unsigned PHT_N  = 64;
    localparam int unsigned GHR_N  = 6;
    localparam int unsigned TAG_SH = 2 + $clog2(BTB_N);
    localparam logic [31:0] FILL   = 32'h0000_1000;
`ifdef BPU_GSHARE_EN
    localparam bit GSHARE = 1'b1;
`else
    localparam bit GSHARE = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc_if;
        logic [31:0] pc_id;
        logic        stall;
        logic        is_br;
        logic        taken;
        logic [31:0] target;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        exp_fail;
        logic [31:0] exp_npc;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    bpu_gshare_if #(.XLEN(XLEN)) bus ();

    bpu_gshare #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_N),
        .PHT_ENTRIES (PHT_N),
        .GHR_BITS    (GHR_N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model state
    bit          m_valid [BTB_N];
    logic [31:0] m_tag   [BTB_N];
    logic [31:0] m_tgt   [BTB_N];
    int          m_pht   [PHT_N];
    int          m_ghr;
    bit          r_pred;
    logic [31:0] r_tgt;
    int          r_pidx;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < int'(BTB_N); i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
        end
        for (int i = 0; i < int'(PHT_N); i++) m_pht[i] = 1;
        m_ghr  = 0;
        r_pred = 1'b0;
        r_tgt  = '0;
        r_pidx = 0;
    endfunction

    function automatic int m_pidx(input logic [31:0] pc);
        int p;
        p = int'((pc >> 2) % PHT_N);
        if (GSHARE) p = p ^ m_ghr;
        return p;
    endfunction

    // One clock of the model: expected outputs, then the edge's state change
    task automatic model_step(input stim_t s, output logic e_fail, output logic [31:0] e_npc);
        int          bi;
        int          wi;
        int          pi;
        bit          hit;
        bit          pred;
        logic [31:0] bt;
        bi   = int'((s.pc_if >> 2) % BTB_N);
        hit  = m_valid[bi] && (m_tag[bi] == (s.pc_if >> TAG_SH));
        pi   = m_pidx(s.pc_if);
        pred = hit && (m_pht[pi] >= 2);
        bt   = m_tgt[bi];
        if (s.is_br) e_fail = (r_pred != s.taken) || (s.taken && r_pred && r_tgt != s.target);
        else         e_fail = r_pred;
        if (e_fail) e_npc = (s.is_br && s.taken) ? s.target : s.pc_id + 32'd4;
        else        e_npc = pred ? bt : s.pc_if + 32'd4;
        if (!s.stall) begin
            if (s.is_br) begin
                if (s.taken) m_pht[r_pidx] = (m_pht[r_pidx] == 3) ? 3 : m_pht[r_pidx] + 1;
                else         m_pht[r_pidx] = (m_pht[r_pidx] == 0) ? 0 : m_pht[r_pidx] - 1;
                m_ghr = ((m_ghr << 1) | int'(s.taken)) % (1 << GHR_N);
                if (s.taken) begin
                    wi          = int'((s.pc_id >> 2) % BTB_N);
                    m_valid[wi] = 1'b1;
                    m_tag[wi]   = s.pc_id >> TAG_SH;
                    m_tgt[wi]   = s.target;
                end
            end
            if (e_fail) begin
                r_pred = 1'b0;
                r_tgt  = '0;
                r_pidx = 0;
            end else begin
                r_pred = pred;
                r_tgt  = bt;
                r_pidx = pi;
            end
        end
    endtask

    task automatic apply(input stim_t s, output logic g_fail, output logic [31:0] g_npc);
        @(negedge clk);
        bus.pc_if        = s.pc_if;
        bus.pc_id        = s.pc_id;
        bus.data_stall   = s.stall;
        bus.is_branch_id = s.is_br;
        bus.taken_id     = s.taken;
        bus.target_id    = s.target;
        #2;
        g_fail = bus.fail;
        g_npc  = bus.npc;
    endtask

    // Apply one cycle and compare against the model
    task automatic run_cycle(input string name, input stim_t s, output logic g_fail);
        logic [31:0] g_npc;
        logic        e_fail;
        logic [31:0] e_npc;
        apply(s, g_fail, g_npc);
        model_step(s, e_fail, e_npc);
        check({name, "_fail"}, 32'(g_fail), 32'(e_fail));
        check({name, "_npc"}, g_npc, e_npc);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst              = 1'b0;
        bus.pc_if        = 32'h100;
        bus.pc_id        = FILL;
        bus.data_stall   = 1'b1;
        bus.is_branch_id = 1'b0;
        bus.taken_id     = 1'b0;
        bus.target_id    = '0;
        #2;
        check({name, "_fail"}, 32'(bus.fail), 32'd0);
        check({name, "_npc"}, bus.npc, 32'h104);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic stim_t mk(input logic [31:0] pif, input logic [31:0] pid, input logic st,
                                 input logic br, input logic tk, input logic [31:0] tg);
        stim_t s;
        s.pc_if  = pif;
        s.pc_id  = pid;
        s.stall  = st;
        s.is_br  = br;
        s.taken  = tk;
        s.target = tg;
        return s;
    endfunction

    function automatic void add(input stim_t s, input logic ef, input logic [31:0] en);
        vec_t v;
        v.s        = s;
        v.exp_fail = ef;
        v.exp_npc  = en;
        vq.push_back(v);
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] base;
        case ($urandom_range(0, 2))
            0:       base = 32'h0000_0100;
            1:       base = 32'h0000_0500;
            default: base = 32'hFFFF_FFC0;
        endcase
        return base + 32'(4 * $urandom_range(0, 15));
    endfunction

    initial begin
        logic        g_fail;
        logic        e_fail;
        logic [31:0] g_npc;
        logic [31:0] e_npc;
        int          late;
        stim_t       s;

        rst = 1'b0;
        model_reset();

        // Directed table; history stays saturated so both builds agree
        add(mk(32'h100,      32'h0,   0, 0, 0, 0),         0, 32'h104);
        add(mk(FILL,         32'h100, 0, 0, 0, 0),         0, 32'h1004);
        add(mk(32'hFFFFFFFC, FILL,    0, 0, 0, 0),         0, 32'h0);
        for (int i = 0; i < 6; i++)
            add(mk(FILL, 32'h804, 0, 1, 1, 32'h900),       1, 32'h900);
        add(mk(FILL,         32'h100, 0, 0, 0, 0),         0, 32'h1004);
        add(mk(FILL,         32'h100, 0, 1, 1, 32'h200),   1, 32'h200);
        add(mk(32'h100,      FILL,    0, 0, 0, 0),         0, 32'h200);
        add(mk(FILL,         32'h100, 0, 1, 1, 32'h200),   0, 32'h1004);
        add(mk(32'h100,      FILL,    0, 0, 0, 0),         0, 32'h200);
        add(mk(32'h100,      32'h100, 0, 1, 1, 32'h300),   1, 32'h300);
        add(mk(32'h100,      32'h100, 0, 0, 0, 0),         0, 32'h300);
        add(mk(FILL,         32'h100, 0, 0, 0, 0),         1, 32'h104);
        add(mk(32'h100,      FILL,    0, 0, 0, 0),         0, 32'h300);
        add(mk(FILL,         32'h100, 0, 1, 0, 32'h300),   1, 32'h104);

        do_reset("reset");

        foreach (vq[i]) begin
            apply(vq[i].s, g_fail, g_npc);
            model_step(vq[i].s, e_fail, e_npc);
            check($sformatf("vec%0d_fail", i), 32'(g_fail), 32'(vq[i].exp_fail));
            check($sformatf("vec%0d_npc", i), g_npc, vq[i].exp_npc);
        end

        // Stall: ID record and tables frozen, update lands when stall drops
        run_cycle("stall_fetch", mk(32'h100, FILL, 0, 0, 0, 0), g_fail);
        for (int i = 0; i < 3; i++)
            run_cycle($sformatf("stall_hold%0d", i), mk(FILL, 32'h100, 1, 1, 1, 32'h500), g_fail);
        run_cycle("stall_release", mk(FILL, 32'h100, 0, 1, 1, 32'h500), g_fail);
        run_cycle("stall_after", mk(32'h100, FILL, 0, 0, 0, 0), g_fail);

        // Reset with trained state discards everything
        do_reset("mid_reset");

        // Alternating branch at 0x40: history separates the two outcomes
        late = 0;
        for (int i = 0; i < 16; i++) begin
            run_cycle("alias_fetch", mk(32'h40, FILL, 0, 0, 0, 0), g_fail);
            run_cycle("alias_resolve", mk(FILL, 32'h40, 0, 1, (i % 2) == 0, 32'h80), g_fail);
            if (i >= 8 && g_fail) late++;
        end
        check("alias_late_mispredicts", 32'(late), GSHARE ? 32'd0 : 32'd8);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            s = mk(rand_pc(), rand_pc(), $urandom_range(0, 4) == 0,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_pc());
            run_cycle("random", s, g_fail);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
